// File: rtl/if_fetch_buf.sv
// Instruction fetch buffer: issues sequential fetches to a one-cycle-latency
// instruction memory and queues the returned {addr, inst} pairs for IF/ID.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module if_fetch_buf #(
    parameter int                      DEPTH    = 4,
    parameter logic [`ADDR_WIDTH-1:0]  RESET_PC = 32'h0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_jump_i,
    input  logic [`ADDR_WIDTH-1:0]  new_pc_i,
    output logic [`ADDR_WIDTH-1:0]  pc_o,
    output logic                    inst_ce_o,
    input  logic [`DATA_WIDTH-1:0]  inst_i,
    input  logic                    ready_i,
    output logic                    inst_valid_o,
    output logic [`ADDR_WIDTH-1:0]  inst_addr_o,
    output logic [`DATA_WIDTH-1:0]  inst_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W+1)'(DEPTH);

    logic [`ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [`ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                   inflight_q, inflight_d;
    logic [PTR_W-1:0]       wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]       count_q,    count_d;

    logic [`ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [`DATA_WIDTH-1:0] inst_mem [DEPTH];

    logic [CNT_W:0] occ_s;
    logic           has_entry_s;
    logic           fetch_s;
    logic           push_s;
    logic           pop_s;
    logic           valid_s;

    // Occupancy counts the outstanding fetch so a returning response always has a slot.
    always_comb begin
        occ_s       = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        has_entry_s = (count_q != {CNT_W{1'b0}});
        // rst_i gates the request so nothing is issued while reset is held.
        fetch_s     = rst_i & ~flush_jump_i & (occ_s < DEPTH_OCC);
        valid_s     = has_entry_s & ~flush_jump_i;
        push_s      = inflight_q & ~flush_jump_i;
        pop_s       = valid_s & ready_i;
    end

    // Next-state for fetch address, in-flight tracking, pointers and occupancy.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        inflight_d = inflight_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush_jump_i) begin
            fetch_pc_d = new_pc_i;
            inflight_d = 1'b0;
            wr_ptr_d   = {PTR_W{1'b0}};
            rd_ptr_d   = {PTR_W{1'b0}};
            count_d    = {CNT_W{1'b0}};
        end else begin
            inflight_d = fetch_s;
            if (fetch_s) begin
                fetch_pc_d = fetch_pc_q + `ADDR_WIDTH'(4);
                req_addr_d = fetch_pc_q;
            end else begin
                fetch_pc_d = fetch_pc_q;
                req_addr_d = req_addr_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc_q <= RESET_PC;
            req_addr_q <= {`ADDR_WIDTH{1'b0}};
            inflight_q <= 1'b0;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry storage; contents are only observed through a nonzero count, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            addr_mem[wr_ptr_q] <= req_addr_q;
            inst_mem[wr_ptr_q] <= inst_i;
        end
    end

    // Head outputs read zero when the buffer is empty.
    always_comb begin
        pc_o         = fetch_pc_q;
        inst_ce_o    = fetch_s;
        inst_valid_o = valid_s;
        if (has_entry_s) begin
            inst_addr_o = addr_mem[rd_ptr_q];
            inst_o      = inst_mem[rd_ptr_q];
        end else begin
            inst_addr_o = {`ADDR_WIDTH{1'b0}};
            inst_o      = {`DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_if_fetch_buf.sv
// Directed bench for if_fetch_buf; a one-cycle memory model returns addr+0x100.

module tb_if_fetch_buf;

    logic        clk_i;
    logic        rst_i;
    logic        flush_jump_i;
    logic [31:0] new_pc_i;
    logic [31:0] pc_o;
    logic        inst_ce_o;
    logic [31:0] inst_i;
    logic        ready_i;
    logic        inst_valid_o;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_o;

    int checks_q;
    int failures_q;
    logic [31:0] fetched_addr [8];
    int          n_fetch;

    if_fetch_buf #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_jump_i (flush_jump_i),
        .new_pc_i     (new_pc_i),
        .pc_o         (pc_o),
        .inst_ce_o    (inst_ce_o),
        .inst_i       (inst_i),
        .ready_i      (ready_i),
        .inst_valid_o (inst_valid_o),
        .inst_addr_o  (inst_addr_o),
        .inst_o       (inst_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Instruction memory model: data for a request appears the following cycle.
    always @(posedge clk_i) begin
        inst_i <= inst_ce_o ? (pc_o + 32'h100) : 32'h0BAD_0BAD;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_q = checks_q + 1;
        if (got !== exp) begin
            failures_q = failures_q + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pc"},    pc_o, 32'h0);
        check_eq({tag, "_ce"},    {31'd0, inst_ce_o}, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd0);
        check_eq({tag, "_addr"},  inst_addr_o, 32'h0);
        check_eq({tag, "_inst"},  inst_o, 32'h0);
    endtask

    // Hold reset for two edges, release at posedge+1 (start of cycle 0).
    task automatic do_reset();
        rst_i = 1'b0;
        flush_jump_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
    endtask

    initial begin
        checks_q = 0;
        failures_q = 0;
        rst_i = 1'b0;
        flush_jump_i = 1'b0;
        new_pc_i = 32'h0;
        ready_i = 1'b0;
        inst_i = 32'h0;

        // Reset state
        tick();
        check_reset_outputs("rst0");

        // Streaming from reset with ready held high
        ready_i = 1'b1;
        do_reset();
        #1;
        check_eq("s_c0_ce", {31'd0, inst_ce_o}, 32'd1);
        check_eq("s_c0_pc", pc_o, 32'h0);
        check_eq("s_c0_valid", {31'd0, inst_valid_o}, 32'd0);
        tick();
        check_eq("s_c1_valid", {31'd0, inst_valid_o}, 32'd0);
        check_eq("s_c1_pc", pc_o, 32'h4);
        tick();
        for (int k = 0; k < 4; k++) begin
            check_eq("s_valid", {31'd0, inst_valid_o}, 32'd1);
            check_eq("s_addr", inst_addr_o, 32'(4 * k));
            check_eq("s_inst", inst_o, 32'h100 + 32'(4 * k));
            tick();
        end

        // Back-pressure: only four fetches, head held at 0
        ready_i = 1'b0;
        rst_i = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        do_reset();
        n_fetch = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (inst_ce_o && n_fetch < 8) begin
                fetched_addr[n_fetch] = pc_o;
                n_fetch = n_fetch + 1;
            end
            tick();
        end
        check_eq("bp_nfetch", 32'(n_fetch), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_eq("bp_fetch_addr", fetched_addr[k], 32'(4 * k));
        end
        #1;
        check_eq("bp_ce_off", {31'd0, inst_ce_o}, 32'd0);
        check_eq("bp_head", inst_addr_o, 32'h0);
        check_eq("bp_head_inst", inst_o, 32'h100);
        check_eq("bp_valid", {31'd0, inst_valid_o}, 32'd1);
        ready_i = 1'b1;
        #1;
        check_eq("bp_pop_ce", {31'd0, inst_ce_o}, 32'd0);
        tick();
        ready_i = 1'b0;
        #1;
        check_eq("bp_refetch_ce", {31'd0, inst_ce_o}, 32'd1);
        check_eq("bp_refetch_pc", pc_o, 32'h10);
        check_eq("bp_head4", inst_addr_o, 32'h4);
        check_eq("bp_head4_inst", inst_o, 32'h104);

        // Flush from a full buffer
        tick();
        tick();
        flush_jump_i = 1'b1;
        new_pc_i = 32'h80;
        ready_i = 1'b1;
        #1;
        check_eq("fl_valid0", {31'd0, inst_valid_o}, 32'd0);
        check_eq("fl_ce0", {31'd0, inst_ce_o}, 32'd0);
        tick();
        flush_jump_i = 1'b0;
        #1;
        check_eq("fl_pc", pc_o, 32'h80);
        check_eq("fl_ce", {31'd0, inst_ce_o}, 32'd1);
        check_eq("fl_valid1", {31'd0, inst_valid_o}, 32'd0);
        tick();
        check_eq("fl_valid2", {31'd0, inst_valid_o}, 32'd0);
        tick();
        check_eq("fl_valid3", {31'd0, inst_valid_o}, 32'd1);
        check_eq("fl_addr", inst_addr_o, 32'h80);
        check_eq("fl_inst", inst_o, 32'h180);
        ready_i = 1'b0;
        tick();
        check_eq("hold_valid", {31'd0, inst_valid_o}, 32'd1);
        check_eq("hold_addr", inst_addr_o, 32'h80);
        check_eq("hold_inst", inst_o, 32'h180);
        ready_i = 1'b1;
        tick();
        check_eq("hold_next", inst_addr_o, 32'h84);

        // Flush while the fetch of 0x8 is in flight
        do_reset();
        tick();
        tick();
        check_eq("if_head0", inst_addr_o, 32'h0);
        check_eq("if_pc8", pc_o, 32'h8);
        tick();
        check_eq("if_head4", inst_addr_o, 32'h4);
        flush_jump_i = 1'b1;
        new_pc_i = 32'h200;
        #1;
        check_eq("if_valid_fl", {31'd0, inst_valid_o}, 32'd0);
        tick();
        flush_jump_i = 1'b0;
        #1;
        check_eq("if_empty", {31'd0, inst_valid_o}, 32'd0);
        check_eq("if_pc", pc_o, 32'h200);
        tick();
        check_eq("if_empty2", {31'd0, inst_valid_o}, 32'd0);
        tick();
        check_eq("if_addr", inst_addr_o, 32'h200);
        check_eq("if_inst", inst_o, 32'h300);

        // Address wrap at the top of the address space
        flush_jump_i = 1'b1;
        new_pc_i = 32'hFFFF_FFFC;
        tick();
        flush_jump_i = 1'b0;
        #1;
        check_eq("wr_pc_top", pc_o, 32'hFFFF_FFFC);
        tick();
        check_eq("wr_pc_zero", pc_o, 32'h0);
        tick();
        check_eq("wr_addr_top", inst_addr_o, 32'hFFFF_FFFC);
        check_eq("wr_inst_top", inst_o, 32'h0000_00FC);
        tick();
        check_eq("wr_addr_zero", inst_addr_o, 32'h0);
        check_eq("wr_inst_zero", inst_o, 32'h100);

        // Reset mid-stream with three entries buffered
        ready_i = 1'b0;
        flush_jump_i = 1'b1;
        new_pc_i = 32'h40;
        tick();
        flush_jump_i = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check_eq("mr_head", inst_addr_o, 32'h40);
        check_eq("mr_ce_full", {31'd0, inst_ce_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        check_reset_outputs("mr_rst");
        tick();
        tick();
        ready_i = 1'b1;
        rst_i = 1'b1;
        #1;
        check_eq("mr_c0_pc", pc_o, 32'h0);
        check_eq("mr_c0_ce", {31'd0, inst_ce_o}, 32'd1);
        check_eq("mr_c0_valid", {31'd0, inst_valid_o}, 32'd0);
        tick();
        tick();
        check_eq("mr_addr", inst_addr_o, 32'h0);
        check_eq("mr_inst", inst_o, 32'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
        $finish;
    end

endmodule

// File: doc/if_fetch_buf.md
IF_FETCH_BUF -- requirements
Module: if_fetch_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered instruction entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush_jump_i, input, 1, redirect request from pipeline control.
REQ-006 SHALL have port new_pc_i, input, `ADDR_WIDTH, redirect target, sampled when flush_jump_i=1.
REQ-007 SHALL have port pc_o, output, `ADDR_WIDTH, fetch address to the instruction memory port.
REQ-008 SHALL have port inst_ce_o, output, 1, fetch request to the instruction memory port.
REQ-009 SHALL have port inst_i, input, `DATA_WIDTH, instruction memory read data, valid the cycle after inst_ce_o=1.
REQ-010 SHALL have port ready_i, input, 1, downstream (IF/ID) accepts the head entry this cycle.
REQ-011 SHALL have port inst_valid_o, output, 1, head entry is valid.
REQ-012 SHALL have port inst_addr_o, output, `ADDR_WIDTH, address of head entry.
REQ-013 SHALL have port inst_o, output, `DATA_WIDTH, instruction of head entry.

Function
REQ-014 SHALL hold a circular FIFO of DEPTH entries {addr, inst}, with read/write pointers and an occupancy count 0..DEPTH.
REQ-015 SHALL hold fetch_pc register driven onto pc_o, and a 1-bit in-flight flag marking a fetch issued last cycle.
REQ-016 SHALL drive inst_ce_o = ~flush_jump_i & ((count + inflight) < DEPTH), combinationally from registered state.
REQ-017 SHALL advance fetch_pc by 4 at each clock edge where inst_ce_o=1, wrapping modulo 2^ADDR_WIDTH.
REQ-018 SHALL set inflight to inst_ce_o at each clock edge, and record the issued address alongside it.
REQ-019 SHALL, when inflight=1 and flush_jump_i=0, write {recorded address, inst_i} at the write pointer; never overflow, guaranteed by REQ-016.
REQ-020 SHALL drive inst_valid_o = (count != 0) & ~flush_jump_i; inst_addr_o/inst_o from head entry combinationally.
REQ-021 SHALL pop the head when inst_valid_o=1 and ready_i=1; ready_i with inst_valid_o=0 has no effect.
REQ-022 SHALL keep count unchanged on simultaneous push and pop; pointers wrap at DEPTH.
REQ-023 SHALL keep head outputs stable while inst_valid_o=1 and ready_i=0.
REQ-024 SHALL, on a clock edge with flush_jump_i=1: clear count and both pointers, drop any in-flight response (no write), clear inflight, load fetch_pc with new_pc_i; no pop occurs.
REQ-025 SHALL issue the first fetch at new_pc_i in the cycle after flush; first redirected entry valid two cycles after flush.
REQ-026 SHALL have a minimum latency of 2 cycles from inst_ce_o=1 to that entry appearing with inst_valid_o=1.
REQ-027 SHALL sustain one instruction per cycle when ready_i is held at 1 and no flush occurs.
REQ-028 SHALL treat back-to-back flushes as independent; only the last new_pc_i takes effect.

Reset
REQ-029 SHALL, while rst_i=0, asynchronously set fetch_pc=RESET_PC, count=0, pointers=0, inflight=0.
REQ-030 SHALL output during reset: pc_o=RESET_PC, inst_ce_o=0, inst_valid_o=0, inst_addr_o=0, inst_o=0.
REQ-031 SHALL issue the first fetch in the first cycle after rst_i deasserts; reset mid-operation discards all entries and in-flight fetches.

Verification
REQ-032 SHALL cover: reset release, ready_i=1, memory returns addr+0x100 -> inst_ce_o high cycle 0 with pc_o=0, inst_valid_o first 1 in cycle 2 with inst_addr_o=0, inst_o=0x100, then addresses 4,8,C one per cycle.
REQ-033 SHALL cover: ready_i=0 from reset -> exactly 4 fetches (0,4,8,C), inst_ce_o=0 thereafter, head held at addr 0; ready_i=1 for one cycle -> fetch of 0x10 next cycle, head becomes 4.
REQ-034 SHALL cover: full buffer, flush_jump_i=1 with new_pc_i=0x80 -> inst_valid_o=0 that cycle, next cycle pc_o=0x80 inst_ce_o=1, inst_valid_o=1 with inst_addr_o=0x80 two cycles after flush; no stale entry ever seen.
REQ-035 SHALL cover: flush in the same cycle as an in-flight response (addr 0x8) -> response not written, occupancy 0 after edge.
REQ-036 SHALL cover: fetch_pc=0xFFFFFFFC -> next issued address 0x00000000.
REQ-037 SHALL cover: rst_i asserted mid-stream with 3 entries buffered -> outputs immediately reset values, after release restart at RESET_PC.
